// File: rtl/mackerel_ide_pkg.sv
// rtl/mackerel_ide_pkg.sv - shared state encoding and default timing for the IDE cycle sequencer
package mackerel_ide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        ACK,
        ERR,
        RECOVER
    } ide_state_e;

    localparam int unsigned DEF_SETUP_CYCLES    = 2;
    localparam int unsigned DEF_ACTIVE_CYCLES   = 6;
    localparam int unsigned DEF_RECOVERY_CYCLES = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;
    localparam int unsigned DEF_CNT_W           = 8;

    // DIOR-/DIOW- stays asserted from strobe start until the CPU is released.
    function automatic logic strobe_state(input ide_state_e s);
        return (s == STROBE) || (s == WAIT) || (s == ACK);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for the asynchronous IORDY input
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ide_cycle_sequencer.sv
// rtl/ide_cycle_sequencer.sv - sequences 68030 bus cycles onto the 16-bit IDE PIO port
module ide_cycle_sequencer
    import mackerel_ide_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
    parameter int unsigned ACTIVE_CYCLES   = DEF_ACTIVE_CYCLES,
    parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic AS_n,
    input  logic DS_n,
    input  logic RW,
    input  logic IDE_SEL,
    input  logic REG_SEL,
    input  logic IDE_RDY,
    output logic IDE_CS0_n,
    output logic IDE_CS1_n,
    output logic IDE_RD_n,
    output logic IDE_WR_n,
    output logic IDE_BUF_n,
    output logic DSACK1_n,
    output logic BERR_n,
    output logic BUSY
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] ACT_LD   = CNT_W'(ACTIVE_CYCLES);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVERY_CYCLES);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ide_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic             reg_q, reg_d;
    logic             rdy_s;
    logic             cnt_last;

    logic cs0_n_q, cs0_n_d;
    logic cs1_n_q, cs1_n_d;
    logic rd_n_q, rd_n_d;
    logic wr_n_q, wr_n_d;
    logic buf_n_q, buf_n_d;
    logic dsack_n_q, dsack_n_d;
    logic berr_n_q, berr_n_d;
    logic busy_q, busy_d;
    logic busy_nx, strobe_nx;

    sync_2ff u_rdy_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (IDE_RDY),
        .q_o   (rdy_s)
    );

    assign cnt_last = (cnt_q == CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        reg_d   = reg_q;
        case (state_q)
            IDLE: begin
                if (IDE_SEL && !AS_n && !DS_n) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    rw_d    = RW;
                    reg_d   = REG_SEL;
                end
            end
            SETUP: begin
                if (AS_n) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end else if (cnt_last) begin
                    state_d = STROBE;
                    cnt_d   = ACT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STROBE: begin
                if (AS_n) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end else if (cnt_last) begin
                    state_d = rdy_s ? ACK : WAIT;
                    cnt_d   = TO_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT: begin
                // A CPU abort beats a same-edge IORDY or timeout.
                if (AS_n) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end else if (rdy_s) begin
                    state_d = ACK;
                end else if (cnt_last) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ACK, ERR: begin
                if (AS_n) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end
            end
            RECOVER: begin
                if (cnt_last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin changes on the same edge as the state.
    always_comb begin
        busy_nx   = (state_d != IDLE);
        strobe_nx = strobe_state(state_d);
        busy_d    = busy_nx;
        cs0_n_d   = !(busy_nx && !reg_d);
        cs1_n_d   = !(busy_nx && reg_d);
        buf_n_d   = !busy_nx;
        rd_n_d    = !(strobe_nx && rw_d);
        wr_n_d    = !(strobe_nx && !rw_d);
        dsack_n_d = (state_d != ACK);
        berr_n_d  = (state_d != ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b1;
            reg_q     <= 1'b0;
            cs0_n_q   <= 1'b1;
            cs1_n_q   <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            buf_n_q   <= 1'b1;
            dsack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            reg_q     <= reg_d;
            cs0_n_q   <= cs0_n_d;
            cs1_n_q   <= cs1_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            buf_n_q   <= buf_n_d;
            dsack_n_q <= dsack_n_d;
            berr_n_q  <= berr_n_d;
            busy_q    <= busy_d;
        end
    end

    assign IDE_CS0_n = cs0_n_q;
    assign IDE_CS1_n = cs1_n_q;
    assign IDE_RD_n  = rd_n_q;
    assign IDE_WR_n  = wr_n_q;
    assign IDE_BUF_n = buf_n_q;
    assign DSACK1_n  = dsack_n_q;
    assign BERR_n    = berr_n_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_ide_cycle_sequencer.sv
// tb/tb_ide_cycle_sequencer.sv - self-checking bench for ide_cycle_sequencer
module tb_ide_cycle_sequencer;

    localparam int S   = 2;
    localparam int ACT = 6;
    localparam int R   = 3;
    localparam int TO  = 255;
    localparam logic [7:0] IDLE_V = 8'b1111_1110;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic AS_n = 1'b1, DS_n = 1'b1, RW = 1'b1, IDE_SEL = 1'b0, REG_SEL = 1'b0, IDE_RDY = 1'b1;
    logic IDE_CS0_n, IDE_CS1_n, IDE_RD_n, IDE_WR_n, IDE_BUF_n, DSACK1_n, BERR_n, BUSY;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ide_cycle_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .AS_n      (AS_n),
        .DS_n      (DS_n),
        .RW        (RW),
        .IDE_SEL   (IDE_SEL),
        .REG_SEL   (REG_SEL),
        .IDE_RDY   (IDE_RDY),
        .IDE_CS0_n (IDE_CS0_n),
        .IDE_CS1_n (IDE_CS1_n),
        .IDE_RD_n  (IDE_RD_n),
        .IDE_WR_n  (IDE_WR_n),
        .IDE_BUF_n (IDE_BUF_n),
        .DSACK1_n  (DSACK1_n),
        .BERR_n    (BERR_n),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] observed();
        return {IDE_CS0_n, IDE_CS1_n, IDE_RD_n, IDE_WR_n, IDE_BUF_n, DSACK1_n, BERR_n, BUSY};
    endfunction

    // Expected pins after edge e of a cycle whose request was taken at edge 0.
    // t = termination edge, a = first edge sampling AS_n high.
    function automatic logic [7:0] expected(int e, bit rs, bit rw, int t, bit err, int a);
        bit busy, term, strobe, dsack, berr;
        busy   = (e <= a + R - 1);
        term   = (t < a);
        strobe = busy && (e >= S) && (e < ((term && err) ? t : a));
        dsack  = term && !err && (e >= t) && (e < a);
        berr   = term && err && (e >= t) && (e < a);
        return {!(busy && !rs), !(busy && rs), !(strobe && rw), !(strobe && !rw),
                !busy, !dsack, !berr, busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // k: edge after which raw IORDY rises (<0: high from the start, huge: never).
    // abort_a > 0 forces AS_n high before that edge instead of after termination.
    task automatic run_cycle(input bit rs, input bit rw, input int k, input int hold,
                             input int abort_a, input bit b2b);
        int  tn, t, a, last;
        bit  err;
        tn = S + ACT;
        if (k >= 0 && k + 3 > tn) tn = k + 3;
        err = (tn > S + ACT + TO);
        t   = err ? S + ACT + TO : tn;
        a   = (abort_a > 0) ? abort_a : t + hold;
        AS_n = 1'b0; DS_n = 1'b0; IDE_SEL = 1'b1; REG_SEL = rs; RW = rw;
        IDE_RDY = (k < 0);
        last = b2b ? a + R : a + R + 1;
        for (int e = 0; e <= last; e++) begin
            @(posedge CLK); #1;
            check($sformatf("cyc%0d_e%0d", cyc, e), observed(), expected(e, rs, rw, t, err, a));
            if (e == k) IDE_RDY = 1'b1;
            if (e == a - 1) begin AS_n = 1'b1; DS_n = 1'b1; IDE_SEL = 1'b0; end
            if (b2b && e == a) begin AS_n = 1'b0; DS_n = 1'b0; IDE_SEL = 1'b1; end
        end
        cyc++;
    endtask

    initial begin
        #1 RST = 1'b1;
        #2 check("reset_async", observed(), IDLE_V);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1 check("reset_idle", observed(), IDLE_V);

        run_cycle(1'b0, 1'b1, -1, 3, 0, 1'b0);        // read CS0
        run_cycle(1'b1, 1'b0, -1, 2, 0, 1'b0);        // write CS1
        run_cycle(1'b0, 1'b1, 12, 2, 0, 1'b0);        // IORDY extension
        run_cycle(1'b1, 1'b0, 100000, 2, 0, 1'b0);    // timeout to bus error
        run_cycle(1'b0, 1'b1, -1, 0, 4, 1'b0);        // abort in strobe
        run_cycle(1'b1, 1'b1, -1, 0, 1, 1'b0);        // abort in setup
        run_cycle(1'b0, 1'b1, -1, 1, 0, 1'b1);        // back-to-back pair
        run_cycle(1'b1, 1'b0, 9, 1, 0, 1'b0);

        // Reset mid-cycle
        AS_n = 1'b0; DS_n = 1'b0; IDE_SEL = 1'b1; REG_SEL = 1'b1; RW = 1'b1; IDE_RDY = 1'b1;
        repeat (6) @(posedge CLK);
        #1 check("pre_reset_busy", observed(), expected(5, 1'b1, 1'b1, S + ACT, 1'b0, 1000));
        #1 RST = 1'b1; AS_n = 1'b1; DS_n = 1'b1; IDE_SEL = 1'b0;
        #1 check("mid_reset", observed(), IDLE_V);
        #1 RST = 1'b0;
        @(posedge CLK); #1 check("post_reset_idle", observed(), IDLE_V);
        run_cycle(1'b0, 1'b0, -1, 2, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            bit rs, rw, b2b;
            int k, hold, ab;
            rs   = 1'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            k    = int'($urandom_range(0, 3)) == 0 ? -1 : int'($urandom_range(0, 24));
            if ($urandom_range(0, 11) == 0) k = 100000;
            hold = int'($urandom_range(1, 4));
            ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, S + ACT)) : 0;
            b2b  = (i < 23) && ($urandom_range(0, 2) == 0);
            run_cycle(rs, rw, k, hold, ab, b2b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
